// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file write arbiter.
// Holds the FSM encoding and the round-robin winner search.
package regfile_pkg;

   localparam logic [0:0] ARB   = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   localparam int unsigned MAX_REQ = 16;
   localparam int unsigned MAX_ID_W = 4;

   typedef struct packed {
      logic                found;
      logic [MAX_ID_W-1:0] idx;
   } rr_result_t;

   // First valid index at or after ptr, wrapping modulo n; lowest offset wins.
   function automatic rr_result_t rr_next(input logic [MAX_ID_W-1:0] ptr,
                                          input logic [MAX_REQ-1:0]  valid_vec,
                                          input int unsigned         n);
      rr_result_t  r;
      int unsigned cand;
      r = '0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         cand = 32'(ptr) + unsigned'(i);
         if (cand >= n) cand = cand - n;
         if ((unsigned'(i) < n) && valid_vec[cand[MAX_ID_W-1:0]]) begin
            r.found = 1'b1;
            r.idx   = cand[MAX_ID_W-1:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, grant index and any flag.
// The pointer is owned and advanced by the parent.
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any
);

   rr_result_t res;

   always_comb begin
      res       = rr_next(MAX_ID_W'(ptr), MAX_REQ'(req), NUM_REQ);
      any       = enable & res.found;
      grant_idx = ID_W'(res.idx);
      grant     = '0;
      if (any) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file write port among NUM_REQ writers,
// plus a clear sequencer that zeroes every register one write per cycle.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned ADDR_SIZE = 3,
   parameter int unsigned REG_MAX   = 2**ADDR_SIZE,
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
   input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
   input  logic                           clr_start,
   output logic                           clr_busy,
   output logic                           clr_done,
   output logic                           wrtEnable,
   output logic [ADDR_SIZE-1:0]           wrtAddr,
   output logic [WORD_SIZE-1:0]           wrtData,
   output logic [ID_W-1:0]                grant_id
);

   localparam int unsigned CNT_W = ADDR_SIZE + 1;

   logic [0:0]           state, state_n;
   logic [ID_W-1:0]      rr_ptr, rr_ptr_n;
   logic [CNT_W-1:0]     clr_cnt, clr_cnt_n;
   logic                 wrt_enable_n;
   logic [ADDR_SIZE-1:0] wrt_addr_n;
   logic [WORD_SIZE-1:0] wrt_data_n;
   logic [ID_W-1:0]      grant_id_n;
   logic                 clr_busy_n, clr_done_n;

   logic                 arb_en;
   logic                 fire;
   logic [ID_W-1:0]      win_idx;
   logic                 last_clr;

   // A clear request steals the cycle from the arbiter.
   assign arb_en   = (state == ARB) && !clr_start;
   assign last_clr = (clr_cnt == CNT_W'(REG_MAX - 1));

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .enable    (arb_en),
      .grant     (req_ready),
      .grant_idx (win_idx),
      .any       (fire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ARB;
         rr_ptr    <= '0;
         clr_cnt   <= '0;
         wrtEnable <= 1'b0;
         wrtAddr   <= '0;
         wrtData   <= '0;
         grant_id  <= '0;
         clr_busy  <= 1'b0;
         clr_done  <= 1'b0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_ptr_n;
         clr_cnt   <= clr_cnt_n;
         wrtEnable <= wrt_enable_n;
         wrtAddr   <= wrt_addr_n;
         wrtData   <= wrt_data_n;
         grant_id  <= grant_id_n;
         clr_busy  <= clr_busy_n;
         clr_done  <= clr_done_n;
      end
   end

   // Next-state and registered-output logic; address/data/grant hold when idle.
   always_comb begin
      state_n      = state;
      rr_ptr_n     = rr_ptr;
      clr_cnt_n    = clr_cnt;
      wrt_enable_n = 1'b0;
      wrt_addr_n   = wrtAddr;
      wrt_data_n   = wrtData;
      grant_id_n   = grant_id;
      clr_busy_n   = clr_busy;
      clr_done_n   = 1'b0;
      case (state)
         ARB: begin
            if (clr_start) begin
               state_n    = CLEAR;
               clr_cnt_n  = '0;
               clr_busy_n = 1'b1;
            end else if (fire) begin
               wrt_enable_n = 1'b1;
               wrt_addr_n   = req_addr[win_idx*ADDR_SIZE +: ADDR_SIZE];
               wrt_data_n   = req_data[win_idx*WORD_SIZE +: WORD_SIZE];
               grant_id_n   = win_idx;
               rr_ptr_n     = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
            end
         end
         CLEAR: begin
            wrt_enable_n = 1'b1;
            wrt_addr_n   = clr_cnt[ADDR_SIZE-1:0];
            wrt_data_n   = '0;
            clr_cnt_n    = clr_cnt + CNT_W'(1);
            if (last_clr) begin
               state_n    = ARB;
               clr_busy_n = 1'b0;
               clr_done_n = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares each presented register file write.
module tb_regfile_write_arbiter;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] data;
      logic        chk_gid;
      logic [1:0]  gid;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [11:0] req_addr;
   logic [63:0] req_data;
   logic        clr_start;
   logic        clr_busy;
   logic        clr_done;
   logic        wrtEnable;
   logic [2:0]  wrtAddr;
   logic [15:0] wrtData;
   logic [1:0]  grant_id;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   regfile_write_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .wrtEnable (wrtEnable),
      .wrtAddr   (wrtAddr),
      .wrtData   (wrtData),
      .grant_id  (grant_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int k, input logic [2:0] a, input logic [15:0] d);
      req_addr[k*3 +: 3]   = a;
      req_data[k*16 +: 16] = d;
   endtask

   task automatic push_w(input logic [2:0] a, input logic [15:0] d,
                         input logic cg, input logic [1:0] g);
      exp_t e;
      e.addr = a; e.data = d; e.chk_gid = cg; e.gid = g;
      exp_q.push_back(e);
   endtask

   // Monitor: every presented write must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && wrtEnable) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                     wrtAddr, wrtData);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(wrtAddr), 32'(e.addr));
            chk("wr_data", 32'(wrtData), 32'(e.data));
            if (e.chk_gid) chk("grant_id", 32'(grant_id), 32'(e.gid));
         end
      end
   end

   initial begin
      rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; clr_start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_wen",   32'(wrtEnable), 32'(0));
      chk("rst_addr",  32'(wrtAddr),   32'(0));
      chk("rst_data",  32'(wrtData),   32'(0));
      chk("rst_gid",   32'(grant_id),  32'(0));
      chk("rst_busy",  32'(clr_busy),  32'(0));
      chk("rst_done",  32'(clr_done),  32'(0));
      rst = 1'b0;

      // Idle after reset release
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_wen",   32'(wrtEnable), 32'(0));
         chk("idle_busy",  32'(clr_busy),  32'(0));
         chk("idle_ready", 32'(req_ready), 32'(0));
      end

      // Single requester 2
      set_req(2, 3'd5, 16'hBEEF);
      req_valid = 4'b0100;
      #1 chk("t2_ready", 32'(req_ready), 32'h4);
      push_w(3'd5, 16'hBEEF, 1'b1, 2'd2);
      tick();
      req_valid = '0;

      // Requester 3 alone brings rr_ptr back to 0
      set_req(3, 3'd7, 16'h3333);
      req_valid = 4'b1000;
      #1 chk("t3_pre_ready", 32'(req_ready), 32'h8);
      push_w(3'd7, 16'h3333, 1'b1, 2'd3);
      tick();

      // All four held: grants 0,1,2,3,0
      for (int k = 0; k < 4; k++) set_req(k, 3'(k + 1), 16'(32'hA000 + k));
      req_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         int k;
         k = c % 4;
         #1 chk("t3_ready", 32'(req_ready), 32'(1 << k));
         push_w(3'(k + 1), 16'(32'hA000 + k), 1'b1, 2'(k));
         tick();
      end
      req_valid = '0;

      // Clear while requester 1 waits
      set_req(1, 3'd6, 16'h1234);
      req_valid = 4'b0010;
      clr_start = 1'b1;
      #1 chk("t4_start_ready", 32'(req_ready), 32'(0));
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < 8; i++) push_w(3'(i), 16'h0000, 1'b0, 2'd0);
      push_w(3'd6, 16'h1234, 1'b1, 2'd1);
      for (int i = 0; i < 8; i++) begin
         chk("t4_busy",  32'(clr_busy),  32'(1));
         chk("t4_ready", 32'(req_ready), 32'(0));
         chk("t4_done",  32'(clr_done),  32'(0));
         tick();
      end
      chk("t4_end_busy",  32'(clr_busy),  32'(0));
      chk("t4_end_done",  32'(clr_done),  32'(1));
      chk("t4_end_ready", 32'(req_ready), 32'h2);
      tick();
      chk("t4_done_pulse", 32'(clr_done), 32'(0));
      req_valid = '0;

      // Async reset at clr_cnt=3 aborts the sweep
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      push_w(3'd0, 16'h0000, 1'b0, 2'd0);
      push_w(3'd1, 16'h0000, 1'b0, 2'd0);
      repeat (3) tick();
      #1 rst = 1'b1;
      #1;
      chk("t5_wen",   32'(wrtEnable), 32'(0));
      chk("t5_addr",  32'(wrtAddr),   32'(0));
      chk("t5_data",  32'(wrtData),   32'(0));
      chk("t5_gid",   32'(grant_id),  32'(0));
      chk("t5_busy",  32'(clr_busy),  32'(0));
      chk("t5_done",  32'(clr_done),  32'(0));
      chk("t5_ready", 32'(req_ready), 32'(0));
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t5_post_done", 32'(clr_done),  32'(0));
         chk("t5_post_busy", 32'(clr_busy),  32'(0));
         chk("t5_post_wen",  32'(wrtEnable), 32'(0));
         tick();
      end
      set_req(1, 3'd2, 16'h5A5A);
      set_req(3, 3'd3, 16'hC3C3);
      req_valid = 4'b1010;
      #1 chk("t5_arb_ready0", 32'(req_ready), 32'h2);
      push_w(3'd2, 16'h5A5A, 1'b1, 2'd1);
      tick();
      req_valid = 4'b1000;
      #1 chk("t5_arb_ready1", 32'(req_ready), 32'h8);
      push_w(3'd3, 16'hC3C3, 1'b1, 2'd3);
      tick();
      req_valid = '0;

      // clr_start during the sweep is ignored
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < 8; i++) push_w(3'(i), 16'h0000, 1'b0, 2'd0);
      for (int i = 0; i < 12; i++) begin
         clr_start = (i == 4);
         #1;
         chk("t6_busy", 32'(clr_busy), 32'(i < 8));
         chk("t6_done", 32'(clr_done), 32'(i == 8));
         tick();
      end
      clr_start = 1'b0;

      repeat (3) tick();
      chk("queue_drained", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
